fetch_prefetch: RTL
===================

// Module: fetch_prefetch
// PURPOSE
// Next-generation fetch stage with decoupled instruction memory and a prefetch queue.
// Issues sequential PC requests to a valid/ready imem port, buffers in-order responses
// with their PCs in a DEPTH-entry FIFO, and hands instructions to decode via valid/ready.
// A redirect from branch/jump resolution flushes the queue and squashes in-flight responses.
// PARAMETERS
// XLEN      32      PC / address width
// ILEN      32      instruction word width
// DEPTH     4       prefetch FIFO entries; power of 2, >= 2
// RESET_PC  32'h0   fetch PC loaded on reset (XLEN bits)
// PORTS
// clk                 in   1     single clock, rising edge
// reset               in   1     asynchronous, active-low reset
// redirect_valid_in   in   1     branch/jump taken this cycle
// redirect_target_in  in   XLEN  new fetch PC; bits [1:0] ignored (forced 00)
// imem_req_valid      out  1     fetch request valid
// imem_req_addr       out  XLEN  fetch address
// imem_req_ready      in   1     imem accepts request
// imem_rsp_valid      in   1     in-order response valid (>= 1 cycle after accept)
// imem_rsp_data       in   ILEN  response instruction word
// inst_valid          out  1     head-of-queue instruction valid
// dec_ready_in        in   1     decode accepts (0 = stall)
// instruction         out  ILEN  head instruction; 0 when queue empty
// current_pc          out  XLEN  PC of head instruction; 0 when empty
// pc_plus_4           out  XLEN  current_pc + 4 (mod 2^XLEN)
// BEHAVIOUR
// - Reset (reset=0, async): fetch_pc=RESET_PC, FIFO empty, outstanding=0, squash=0;
//   inst_valid=0, imem_req_valid=0. Mid-operation reset drops all state immediately.
// - Credit: imem_req_valid = (count + outstanding < DEPTH) && !redirect_valid_in.
//   imem_req_addr = fetch_pc. On accept (valid&&ready): fetch_pc += 4 (wraps), outstanding++.
// - Response: always accepted (credit guarantees space). If squash>0: drop, squash--.
//   Otherwise push {pc_of_oldest_request, data}; outstanding--. Separate PC tag FIFO or
//   rsp_pc counter tracks the PC of each outstanding request.
// - Visibility: pushed entry is visible at inst_valid the cycle after push (no bypass).
//   With 1-cycle imem: request cycle N -> rsp N+1 -> inst_valid N+2.
// - Pop: inst_valid && dec_ready_in. Push and pop in the same cycle are both honoured.
// - Redirect (highest priority): FIFO flushed, fetch_pc = {target[XLEN-1:2],2'b00},
//   squash = outstanding (minus 1 if a response arrives that same cycle; that response
//   is dropped), outstanding = squash value; no request issued that cycle; a pop in the
//   same cycle is still counted by decode but the entry is discarded.
// - Redirect while squash>0 accumulates: squash covers every pre-redirect response.
// - Counters: count, outstanding, squash each clog2(DEPTH+1) bits; never exceed DEPTH.
// - Steady-state throughput 1 instr/cycle with 1-cycle imem and DEPTH >= 3.
// - Full: no request issued; decode backpressure never drops an instruction.
// STRUCTURE
// - fetch_pkg: XLEN/ILEN defaults, PC_STEP=4, NOP=32'h00000013,
//   typedef fetch_entry_t {pc, instr}.
// - Sub-module fetch_fifo (sync FIFO, DEPTH entries, push/pop/flush, count output);
//   top holds fetch_pc, outstanding, squash and the credit/redirect logic.
// TESTING
// 1 Reset RESET_PC=0x100, 1-cycle imem, dec_ready=1 -> requests 0x100,0x104,0x108...;
//   inst_valid first at cycle 2, one instr/cycle, pc_plus_4 = current_pc+4.
// 2 dec_ready=0 for 10 cycles -> count reaches DEPTH=4, imem_req_valid=0, no loss;
//   release -> 4 instrs popped in order, then streaming resumes.
// 3 3-cycle imem latency, 2 outstanding, redirect to 0x2002 -> both stale rsps dropped,
//   next request addr 0x2000, first delivered PC 0x2000.
// 4 Redirect in same cycle as rsp_valid -> that rsp dropped, queue empty next cycle.
// 5 fetch_pc=0xFFFFFFFC -> next request 0x00000000; pc_plus_4 of head 0xFFFFFFFC = 0.
// 6 Assert reset mid-stream with 3 queued -> inst_valid=0 and imem_req_valid=0 at once;
//   after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch/prefetch block.
//   XLEN_DEF / ILEN_DEF : default PC and instruction widths
//   PC_STEP             : sequential fetch increment in bytes
//   NOP                 : canonical no-op encoding (addi x0,x0,0)
//   fetch_entry_t       : one queued instruction with its PC (default widths)
package fetch_pkg;

  localparam int XLEN_DEF = 32;
  localparam int ILEN_DEF = 32;
  localparam int PC_STEP  = 4;
  localparam logic [ILEN_DEF-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO, DEPTH entries (power of 2).
//   clk, reset (async, active low)
//   push/data_in : write one entry (ignored when full)
//   pop          : remove head entry (ignored when empty)
//   flush        : drop all entries; wins over push and pop
//   head         : head entry data, valid when !empty
//   empty, count : occupancy status
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [W-1:0]                   data_in,
  input  logic                           pop,
  input  logic                           flush,
  output logic [W-1:0]                   head,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // pointers wrap naturally because DEPTH is a power of 2
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // storage is datapath only; no reset needed
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch stage with decoupled imem port and prefetch queue.
//   clk, reset (async, active low)
//   redirect_valid_in/redirect_target_in : taken branch/jump, flushes queue
//   imem_req_valid/addr/ready            : sequential fetch requests
//   imem_rsp_valid/data                  : in-order responses
//   inst_valid/dec_ready_in              : handoff to decode
//   instruction/current_pc/pc_plus_4     : head of queue (0 when empty)
// Credit scheme: a request is only issued when queued + in-flight < DEPTH,
// so every response has a guaranteed slot and responses are never stalled.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              ILEN     = ILEN_DEF,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid_in,
  input  logic [XLEN-1:0] redirect_target_in,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            dec_ready_in,
  output logic [ILEN-1:0] instruction,
  output logic [XLEN-1:0] current_pc,
  output logic [XLEN-1:0] pc_plus_4
);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [XLEN-1:0]      fetch_pc;    // next address to request
  logic [XLEN-1:0]      rsp_pc;      // PC of the oldest non-squashed in-flight request
  logic [CW-1:0]        outstanding; // all in-flight requests, squashed ones included
  logic [CW-1:0]        squash;      // in-flight responses still to be discarded
  logic [CW-1:0]        count;
  logic [XLEN+ILEN-1:0] head;
  logic                 empty;
  logic                 credit, accept, push, pop, rsp_drop;
  logic [XLEN-1:0]      target;

  assign target = {redirect_target_in[XLEN-1:2], 2'b00};

  assign credit         = ({1'b0, count} + {1'b0, outstanding}) < DEPTH_C;
  // reset gating keeps the port quiet while reset is held (counters read 0 then)
  assign imem_req_valid = credit && !redirect_valid_in && reset;
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (squash != '0);
  assign push     = imem_rsp_valid && (squash == '0) && !redirect_valid_in;
  assign pop      = inst_valid && dec_ready_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      squash      <= '0;
    end else if (redirect_valid_in) begin
      // everything still in flight after this cycle predates the redirect,
      // so squash it all; a response arriving now is dropped on the spot
      fetch_pc    <= target;
      rsp_pc      <= target;
      outstanding <= outstanding - CW'(imem_rsp_valid);
      squash      <= outstanding - CW'(imem_rsp_valid);
    end else begin
      if (accept)   fetch_pc <= fetch_pc + XLEN'(PC_STEP);
      if (push)     rsp_pc   <= rsp_pc + XLEN'(PC_STEP);
      if (rsp_drop) squash   <= squash - CW'(1);
      outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);
    end
  end

  fetch_fifo #(.W(XLEN+ILEN), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .data_in ({rsp_pc, imem_rsp_data}),
    .pop     (pop),
    .flush   (redirect_valid_in),
    .head    (head),
    .empty   (empty),
    .count   (count)
  );

  assign inst_valid  = !empty;
  assign instruction = inst_valid ? head[ILEN-1:0]    : '0;
  assign current_pc  = inst_valid ? head[ILEN+:XLEN]  : '0;
  assign pc_plus_4   = current_pc + XLEN'(PC_STEP);

endmodule
